debug_bridge: RTL and testbench
===============================

# debug_bridge

Byte-stream-to-memory-bus initiator. Accepts framed write/read commands from a byte source (UART receive side), issues single-word transactions on the SoC memory bus as a second initiator alongside the CPU, and returns acknowledge/read-data bytes to a byte sink (UART transmit side). Used for program loading into BRAM and for peripheral inspection without the CPU.

## Interface
Parameters:
- TIMEOUT, 1024: bus-wait cycles before abort (only with timeout feature).

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  input byte present.
- rx_data  in  8  input byte.
- rx_ready  out  1  bridge accepts byte this cycle.
- tx_valid  out  1  output byte present.
- tx_data  out  8  output byte.
- tx_ready  in  1  sink accepts byte this cycle.
- memory_valid  out  1  transaction request.
- memory_instr  out  1  constant 0.
- memory_addr  out  32  word address, bits [1:0] forced 0.
- memory_wdata  out  32  write data.
- memory_wstrb  out  4  4'hF write, 4'h0 read.
- memory_rdata  in  32  read data, valid when memory_ready=1.
- memory_ready  in  1  transaction complete.

## Operation
- Frame formats, multi-byte fields little-endian (LSB first):
  - Write: 0x57, addr[4], data[4] -> bus write -> response 0x4B.
  - Read: 0x52, addr[4] -> bus read -> response rdata[4], LSB first.
  - Any other first byte: discarded, stay IDLE, no response.
- Byte accepted on rx_valid & rx_ready. rx_ready=1 only in IDLE, ADDR, DATA.
- States:
  - IDLE: on command byte, latch op (W/R), clear byte count, go ADDR.
  - ADDR: shift byte into addr[8*cnt+:8]; after 4th byte go DATA (W) or BUS (R).
  - DATA: shift into wdata; after 4th byte go BUS.
  - BUS: memory_valid=1, addr/wdata/wstrb stable. On memory_ready: capture rdata, go RESP.
  - RESP: tx_valid=1; byte advances on tx_valid & tx_ready. W: 1 byte; R: 4 bytes. After last, go IDLE.
- 2-bit byte counter wraps 3->0 at field end.
- Address bits [1:0] received are ignored.

## Timing
- Reset values: rx_ready=0 (asserted in IDLE after reset release), tx_valid=0, tx_data=0, memory_valid=0, memory_addr=0, memory_wdata=0, memory_wstrb=0, memory_instr=0.
- All outputs registered.
- memory_valid rises the cycle after the final frame byte is accepted; held with stable fields until memory_ready sampled high; low on the following cycle.
- memory_ready in the first BUS cycle (zero-wait responder) is legal; memory_ready=1 while memory_valid=0 is ignored.
- tx_valid rises the cycle after memory_ready; tx_data held until accepted.
- Bytes presented during BUS/RESP see rx_ready=0; source holds them.
- Reset mid-frame or mid-transaction: abandon immediately, return to IDLE, no response.
- Back-to-back frames: next command byte accepted the cycle after the last response byte is taken.

## Configuration
- DEBUG_BRIDGE_TIMEOUT_EN defined: counter runs in BUS; after TIMEOUT cycles without memory_ready, drop memory_valid, send single byte 0xEE (both W and R), go IDLE.
- Undefined: BUS waits indefinitely; counter absent.

## Structure
- Shared configure package: command constants (0x57, 0x52), response constants (0x4B, 0xEE), state enum typedef.
- Single module; no sub-module.

## Test plan
- Write frame 57 00 00 00 80 EF BE AD DE -> one bus write addr=0x80000000, wdata=0xDEADBEEF, wstrb=F; tx 0x4B.
- Read frame 52 00 00 00 80 with rdata=0x12345678 after 3 wait cycles -> memory_valid held 4 cycles; tx 78 56 34 12.
- Unknown byte 0x41 then read frame -> 0x41 dropped, read completes normally.
- tx_ready low for 5 cycles mid-response -> tx_data stable, no lost/duplicated bytes.
- Reset asserted after 3 address bytes -> outputs to reset values; new write frame completes correctly.
- DEBUG_BRIDGE_TIMEOUT_EN, TIMEOUT=16, responder never ready -> memory_valid low after 16 cycles, tx 0xEE, back in IDLE.

Source files
------------

// File: rtl/debug_bridge_pkg.sv
// debug_bridge shared definitions: frame command/response bytes
// and the bridge state encoding.
package debug_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_e;

endpackage

// File: rtl/debug_bridge.sv
// Byte-stream to memory-bus initiator (UART debug/program loader).
// Optional bus-wait abort: define DEBUG_BRIDGE_TIMEOUT_EN.
module debug_bridge
  import debug_bridge_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready
);

  state_e      state_q;
  state_e      state_d;
  logic [1:0]  cnt;
  logic        op_wr;
  logic        err;
  logic [31:0] rdata_q;
  logic        rx_fire;
  logic        tx_fire;
  logic        bus_done;
  logic        is_cmd;
  logic        resp_last;
  logic        tmo_hit;

  assign memory_instr = 1'b0;
  assign rx_fire   = rx_valid & rx_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign bus_done  = memory_valid & memory_ready;
  assign is_cmd    = (rx_data == CMD_WRITE) ||
                     (rx_data == CMD_READ);
  assign resp_last = op_wr | err | (cnt == 2'd3);

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state_q != S_BUS) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state_q == S_BUS) && !memory_ready &&
                   (tmo_cnt == TW'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (rx_fire && is_cmd) state_d = S_ADDR;
      S_ADDR:
        if (rx_fire && cnt == 2'd3)
          state_d = op_wr ? S_DATA : S_BUS;
      S_DATA:
        if (rx_fire && cnt == 2'd3) state_d = S_BUS;
      S_BUS:
        if (bus_done || tmo_hit) state_d = S_RESP;
      S_RESP:
        if (tx_fire && resp_last) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Handshake outputs follow the next state so they are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready     <= 1'b0;
      tx_valid     <= 1'b0;
      memory_valid <= 1'b0;
    end else begin
      rx_ready     <= (state_d == S_IDLE) ||
                      (state_d == S_ADDR) ||
                      (state_d == S_DATA);
      tx_valid     <= (state_d == S_RESP);
      memory_valid <= (state_d == S_BUS);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      op_wr        <= 1'b0;
      err          <= 1'b0;
      rdata_q      <= '0;
      tx_data      <= '0;
      memory_addr  <= '0;
      memory_wdata <= '0;
      memory_wstrb <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_fire && is_cmd) begin
            op_wr <= (rx_data == CMD_WRITE);
            err   <= 1'b0;
            cnt   <= '0;
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            memory_addr[{cnt, 3'b000} +: 8] <=
              (cnt == 2'd0) ? {rx_data[7:2], 2'b00} : rx_data;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3)
              memory_wstrb <= op_wr ? 4'hF : 4'h0;
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            memory_wdata[{cnt, 3'b000} +: 8] <= rx_data;
            cnt <= cnt + 2'd1;
          end
        end
        S_BUS: begin
          if (bus_done) begin
            rdata_q <= memory_rdata;
            tx_data <= op_wr ? RSP_ACK : memory_rdata[7:0];
          end else if (tmo_hit) begin
            err     <= 1'b1;
            tx_data <= RSP_ERR;
          end
        end
        S_RESP: begin
          if (tx_fire) begin
            cnt <= cnt + 2'd1;
            if (!resp_last) begin
              tx_data <= rdata_q[15:8];
              rdata_q <= rdata_q >> 8;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_bridge.sv
// Self-checking bench for debug_bridge: directed frames plus randomized
// frame streams against a frame-level reference model.
module tb_debug_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        memory_valid;
  logic        memory_instr;
  logic [31:0] memory_addr;
  logic [31:0] memory_wdata;
  logic [3:0]  memory_wstrb;
  logic [31:0] memory_rdata;
  logic        memory_ready;

  always #5 clk = ~clk;

  debug_bridge #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .memory_valid (memory_valid),
    .memory_instr (memory_instr),
    .memory_addr  (memory_addr),
    .memory_wdata (memory_wdata),
    .memory_wstrb (memory_wstrb),
    .memory_rdata (memory_rdata),
    .memory_ready (memory_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          vlen;
  } txn_t;

  int tests = 0;
  int fails = 0;

  // Bus responder state
  txn_t        log_q[$];
  logic [31:0] rdq[$];
  int          resp_wait = 0;
  bit          rand_wait = 0;
  bit          never_ready = 0;
  bit          spurious = 0;
  int          vcnt = 0;
  int          wcnt = 0;
  int          last_vlen = 0;

  // Byte sink state
  logic [7:0]  txq[$];
  bit          tx_rand = 0;
  int          stall_at = -1;
  int          stall_len = 0;
  bit          prev_pend = 0;
  logic [7:0]  prev_data = 8'h00;
  int          stab_err = 0;

  always @(negedge clk) begin
    if (memory_valid) begin
      vcnt++;
      if (!never_ready && wcnt >= resp_wait) begin
        txn_t t;
        memory_ready = 1'b1;
        memory_rdata = (rdq.size() > 0) ? rdq.pop_front() : $urandom;
        t.addr  = memory_addr;
        t.wdata = memory_wdata;
        t.wstrb = memory_wstrb;
        t.vlen  = vcnt;
        log_q.push_back(t);
        if (rand_wait) resp_wait = $urandom_range(0, 4);
        wcnt = 0;
      end else begin
        memory_ready = 1'b0;
        memory_rdata = $urandom;
        wcnt++;
      end
    end else begin
      if (vcnt > 0) last_vlen = vcnt;
      vcnt = 0;
      wcnt = 0;
      memory_ready = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      memory_rdata = $urandom;
    end
  end

  always @(negedge clk) begin
    if (prev_pend && (!tx_valid || tx_data !== prev_data)) stab_err++;
    if (stall_len > 0 && txq.size() == stall_at && tx_valid) begin
      tx_ready = 1'b0;
      stall_len--;
    end else begin
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    prev_pend = tx_valid && !tx_ready;
    prev_data = tx_data;
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL rx_accept timeout byte=%02h", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 3000 && txq.size() < n; i++) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    log_q.delete();
    rdq.delete();
    txq.delete();
    stab_err = 0;
  endtask

  task automatic test_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({rx_ready, tx_valid, tx_data, memory_valid} !== 11'd0) begin
      fails++;
      $display("FAIL reset_hs got rx_ready=%b tx_valid=%b tx_data=%02h mv=%b want 0",
               rx_ready, tx_valid, tx_data, memory_valid);
    end
    tests++;
    if ({memory_addr, memory_wdata, memory_wstrb, memory_instr} !== 69'd0) begin
      fails++;
      $display("FAIL reset_bus got addr=%h wdata=%h wstrb=%h instr=%b want 0",
               memory_addr, memory_wdata, memory_wstrb, memory_instr);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release rx_ready got %b want 1", rx_ready);
    end
  endtask

  task automatic test_write();
    clear_logs();
    resp_wait = 0;
    send_byte(8'h57);
    send_word(32'h80000000);
    send_word(32'hDEADBEEF);
    tests++;
    if (memory_valid !== 1'b1 || rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL wr_valid_rise got mv=%b rx_ready=%b want 1 0",
               memory_valid, rx_ready);
    end
    for (int i = 0; i < 3000 && txq.size() < 1; i++) @(posedge clk);
    @(negedge clk);
    tests++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL wr_b2b got rx_ready=%b tx_valid=%b want 1 0",
               rx_ready, tx_valid);
    end
    tests++;
    if (log_q.size() !== 1) begin
      fails++;
      $display("FAIL wr_count got %0d want 1", log_q.size());
    end else begin
      tests++;
      if (log_q[0].addr !== 32'h80000000 || log_q[0].wdata !== 32'hDEADBEEF ||
          log_q[0].wstrb !== 4'hF || log_q[0].vlen !== 1) begin
        fails++;
        $display("FAIL wr_txn got a=%h d=%h s=%h v=%0d want 80000000 deadbeef f 1",
                 log_q[0].addr, log_q[0].wdata, log_q[0].wstrb, log_q[0].vlen);
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (txq.size() !== 1 || txq[0] !== 8'h4B) begin
      fails++;
      $display("FAIL wr_resp got n=%0d b0=%02h want 1 4b", txq.size(),
               txq.size() > 0 ? txq[0] : 8'hxx);
    end
  endtask

  task automatic test_read_wait();
    logic [7:0] exp[4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    clear_logs();
    resp_wait = 3;
    rdq.push_back(32'h12345678);
    send_byte(8'h52);
    send_word(32'h80000000);
    wait_tx(4);
    tests++;
    if (log_q.size() !== 1) begin
      fails++;
      $display("FAIL rd_count got %0d want 1", log_q.size());
    end else begin
      tests++;
      if (log_q[0].addr !== 32'h80000000 || log_q[0].wstrb !== 4'h0 ||
          log_q[0].vlen !== 4) begin
        fails++;
        $display("FAIL rd_txn got a=%h s=%h v=%0d want 80000000 0 4",
                 log_q[0].addr, log_q[0].wstrb, log_q[0].vlen);
      end
    end
    tests++;
    if (txq.size() !== 4) begin
      fails++;
      $display("FAIL rd_resp_n got %0d want 4", txq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (txq[i] !== exp[i]) begin
          fails++;
          $display("FAIL rd_byte%0d got %02h want %02h", i, txq[i], exp[i]);
        end
      end
    end
    resp_wait = 0;
  endtask

  task automatic test_unknown();
    clear_logs();
    spurious = 1;
    rdq.push_back(32'hCAFE0123);
    send_byte(8'h41);
    repeat (4) @(negedge clk);
    send_byte(8'h52);
    send_word(32'h0000_1007);
    wait_tx(4);
    repeat (4) @(negedge clk);
    spurious = 0;
    tests++;
    if (log_q.size() !== 1 || log_q[0].addr !== 32'h0000_1004) begin
      fails++;
      $display("FAIL unk_txn got n=%0d addr=%h want 1 00001004", log_q.size(),
               log_q.size() > 0 ? log_q[0].addr : 32'hx);
    end
    tests++;
    if (txq.size() !== 4 || {txq[3], txq[2], txq[1], txq[0]} !== 32'hCAFE0123) begin
      fails++;
      $display("FAIL unk_resp got n=%0d want 4 bytes of cafe0123", txq.size());
    end
  endtask

  task automatic test_tx_stall();
    logic [31:0] rd;
    clear_logs();
    rd = $urandom;
    rdq.push_back(rd);
    stall_at  = 2;
    stall_len = 5;
    send_byte(8'h52);
    send_word($urandom);
    wait_tx(4);
    repeat (4) @(negedge clk);
    tests++;
    if (stall_len !== 0 || stab_err !== 0) begin
      fails++;
      $display("FAIL stall_stable got left=%0d unstable=%0d want 0 0",
               stall_len, stab_err);
    end
    tests++;
    if (txq.size() !== 4 || {txq[3], txq[2], txq[1], txq[0]} !== rd) begin
      fails++;
      $display("FAIL stall_resp got n=%0d want 4 bytes of %h", txq.size(), rd);
    end
    stall_at = -1;
  endtask

  task automatic test_reset_mid();
    clear_logs();
    send_byte(8'h57);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'h3C);
    rst = 1'b0;
    #1;
    tests++;
    if ({rx_ready, tx_valid, tx_data, memory_valid, memory_addr,
         memory_wdata, memory_wstrb, memory_instr} !== 80'd0) begin
      fails++;
      $display("FAIL midrst_out got rr=%b tv=%b a=%h d=%h want all 0",
               rx_ready, tx_valid, memory_addr, memory_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_byte(8'h57);
    send_word(32'h0000_0010);
    send_word(32'h1122_3344);
    wait_tx(1);
    repeat (4) @(negedge clk);
    tests++;
    if (log_q.size() !== 1 || log_q[0].addr !== 32'h10 ||
        log_q[0].wdata !== 32'h11223344 || log_q[0].wstrb !== 4'hF) begin
      fails++;
      $display("FAIL midrst_txn got n=%0d want 1 write 10<=11223344", log_q.size());
    end
    tests++;
    if (txq.size() !== 1 || txq[0] !== 8'h4B) begin
      fails++;
      $display("FAIL midrst_resp got n=%0d want single 4b", txq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes[$];
    logic [7:0]  exp_tx[$];
    txn_t        exp_txn[$];
    txn_t        t;
    logic [31:0] a, d, r;
    logic [7:0]  j;
    bit          wr;
    clear_logs();
    tx_rand   = 1;
    rand_wait = 1;
    spurious  = 1;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom);
        if (j == 8'h57 || j == 8'h52) j = 8'h00;
        bytes.push_back(j);
      end
      wr = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
      r = $urandom;
      rdq.push_back(r);
      bytes.push_back(wr ? 8'h57 : 8'h52);
      for (int i = 0; i < 4; i++) bytes.push_back(a[8*i +: 8]);
      if (wr) for (int i = 0; i < 4; i++) bytes.push_back(d[8*i +: 8]);
      t.addr  = {a[31:2], 2'b00};
      t.wdata = d;
      t.wstrb = wr ? 4'hF : 4'h0;
      t.vlen  = 0;
      exp_txn.push_back(t);
      if (wr) exp_tx.push_back(8'h4B);
      else for (int i = 0; i < 4; i++) exp_tx.push_back(r[8*i +: 8]);
    end
    foreach (bytes[i]) send_byte(bytes[i]);
    wait_tx(exp_tx.size());
    repeat (4) @(negedge clk);
    tx_rand   = 0;
    rand_wait = 0;
    spurious  = 0;
    resp_wait = 0;
    tests++;
    if (log_q.size() !== exp_txn.size()) begin
      fails++;
      $display("FAIL b2b_txn_n got %0d want %0d", log_q.size(), exp_txn.size());
    end else begin
      foreach (exp_txn[i]) begin
        tests++;
        if (log_q[i].addr !== exp_txn[i].addr ||
            log_q[i].wstrb !== exp_txn[i].wstrb ||
            (exp_txn[i].wstrb == 4'hF && log_q[i].wdata !== exp_txn[i].wdata)) begin
          fails++;
          $display("FAIL b2b_txn%0d got a=%h d=%h s=%h want a=%h d=%h s=%h", i,
                   log_q[i].addr, log_q[i].wdata, log_q[i].wstrb,
                   exp_txn[i].addr, exp_txn[i].wdata, exp_txn[i].wstrb);
        end
      end
    end
    tests++;
    if (txq.size() !== exp_tx.size()) begin
      fails++;
      $display("FAIL b2b_tx_n got %0d want %0d", txq.size(), exp_tx.size());
    end else begin
      foreach (exp_tx[i]) begin
        tests++;
        if (txq[i] !== exp_tx[i]) begin
          fails++;
          $display("FAIL b2b_tx%0d got %02h want %02h", i, txq[i], exp_tx[i]);
        end
      end
    end
    tests++;
    if (stab_err !== 0) begin
      fails++;
      $display("FAIL b2b_tx_stable got %0d changes want 0", stab_err);
    end
  endtask

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    never_ready = 1;
    last_vlen = 0;
    send_byte(8'h52);
    send_word(32'h4000_0000);
    wait_tx(1);
    repeat (3) @(negedge clk);
    never_ready = 0;
    tests++;
    if (last_vlen !== 16 || log_q.size() !== 0) begin
      fails++;
      $display("FAIL tmo_vlen got %0d n=%0d want 16 0", last_vlen, log_q.size());
    end
    tests++;
    if (txq.size() !== 1 || txq[0] !== 8'hEE) begin
      fails++;
      $display("FAIL tmo_resp got n=%0d want single ee", txq.size());
    end
    tests++;
    if (rx_ready !== 1'b1 || memory_valid !== 1'b0) begin
      fails++;
      $display("FAIL tmo_idle got rr=%b mv=%b want 1 0", rx_ready, memory_valid);
    end
    txq.delete();
    send_byte(8'h57);
    send_word(32'h20);
    send_word(32'h55AA55AA);
    wait_tx(1);
    tests++;
    if (txq.size() !== 1 || txq[0] !== 8'h4B || log_q.size() !== 1) begin
      fails++;
      $display("FAIL tmo_after got n=%0d txns=%0d want 1 ack 1 txn",
               txq.size(), log_q.size());
    end
  endtask
`endif

  initial begin
    memory_ready = 1'b0;
    memory_rdata = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_unknown();
    test_tx_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
